// File: rtl/gray_ptr_counter.sv
// rtl/gray_ptr_counter.sv - binary/Gray pointer counter with remote-pointer synchronizer and distance
//
// Ports:
//   clk          rising-edge clock (only clock)
//   rst_n        asynchronous active-low reset
//   inc          advance local pointer by one
//   clr          synchronous clear of local pointer, wins over inc
//   bin_ptr      registered local binary pointer
//   gray_ptr     registered Gray encoding of bin_ptr
//   wrap         one-cycle pulse after pointer rolls from all-ones to zero
//   remote_gray  asynchronous Gray pointer from another domain
//   remote_bin   synchronized remote pointer decoded to binary
//   distance     (bin_ptr - remote_bin) mod 2^WIDTH
module gray_ptr_counter #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] bin_ptr,
    output logic [WIDTH-1:0] gray_ptr,
    output logic             wrap,
    input  logic [WIDTH-1:0] remote_gray,
    output logic [WIDTH-1:0] remote_bin,
    output logic [WIDTH-1:0] distance
);

    logic [WIDTH-1:0] bin_next;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    always_comb begin
        bin_next = bin_ptr;
        if (clr) begin
            bin_next = '0;
        end else if (inc) begin
            bin_next = bin_ptr + 1'b1;
        end
    end

    // Gray is registered from bin_next so the output that crosses domains
    // comes straight off flops and can never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_ptr  <= '0;
            gray_ptr <= '0;
            wrap     <= 1'b0;
        end else begin
            bin_ptr  <= bin_next;
            gray_ptr <= bin_next ^ (bin_next >> 1);
            wrap     <= !clr && inc && (bin_ptr == {WIDTH{1'b1}});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= remote_gray;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        remote_bin = '0;
        remote_bin[WIDTH-1] = sync_q[SYNC_STAGES-1][WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            remote_bin[i] = remote_bin[i+1] ^ sync_q[SYNC_STAGES-1][i];
        end
    end

    assign distance = bin_ptr - remote_bin;

endmodule

// File: tb/tb_gray_ptr_counter.sv
// tb/tb_gray_ptr_counter.sv - directed self-checking bench for gray_ptr_counter
module tb_gray_ptr_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       inc;
    logic       clr;
    logic [3:0] bin_ptr;
    logic [3:0] gray_ptr;
    logic       wrap;
    logic [3:0] remote_gray;
    logic [3:0] remote_bin;
    logic [3:0] distance;

    int checks = 0;
    int errors = 0;

    gray_ptr_counter #(.WIDTH(4), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc         (inc),
        .clr         (clr),
        .bin_ptr     (bin_ptr),
        .gray_ptr    (gray_ptr),
        .wrap        (wrap),
        .remote_gray (remote_gray),
        .remote_bin  (remote_bin),
        .distance    (distance)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] gray_seq [16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101,
                                  4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                  4'b1011, 4'b1001, 4'b1000, 4'b0000};
    logic [3:0] prev_gray;

    initial begin
        rst_n       = 1'b0;
        inc         = 1'b0;
        clr         = 1'b0;
        remote_gray = 4'b1111;

        // Reset holds everything at zero despite activity
        for (int i = 0; i < 4; i++) begin
            inc = ~inc;
            step();
        end
        check("rst_bin", bin_ptr, 4'h0);
        check("rst_gray", gray_ptr, 4'h0);
        check("rst_wrap", wrap, 1'b0);
        check("rst_rbin", remote_bin, 4'h0);
        check("rst_dist", distance, 4'h0);

        // Full count through wrap
        remote_gray = 4'b0000;
        inc         = 1'b1;
        rst_n       = 1'b1;
        prev_gray   = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            step();
            check($sformatf("cnt_gray%0d", i), gray_ptr, gray_seq[i]);
            check($sformatf("cnt_ham%0d", i), 8'($countones(gray_ptr ^ prev_gray)), 8'd1);
            check($sformatf("cnt_wrap%0d", i), wrap, (i == 15) ? 1'b1 : 1'b0);
            prev_gray = gray_ptr;
        end
        check("cnt_dist", distance, 4'h0);

        // Count to 5, hold, then clr+inc
        for (int i = 0; i < 5; i++) step();
        check("pre_hold_wrap", wrap, 1'b0);
        inc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("hold_bin%0d", i), bin_ptr, 4'b0101);
            check($sformatf("hold_gray%0d", i), gray_ptr, 4'b0111);
        end
        clr = 1'b1;
        inc = 1'b1;
        step();
        check("clr_bin", bin_ptr, 4'h0);
        check("clr_gray", gray_ptr, 4'h0);
        check("clr_wrap", wrap, 1'b0);

        // clr+inc at all-ones gives no wrap
        clr = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check("ones_bin", bin_ptr, 4'hF);
        check("ones_gray", gray_ptr, 4'b1000);
        clr = 1'b1;
        step();
        check("clrwrap_bin", bin_ptr, 4'h0);
        check("clrwrap_wrap", wrap, 1'b0);
        clr = 1'b0;
        inc = 1'b0;
        step();
        check("clrwrap_wrap2", wrap, 1'b0);

        // Synchronizer latency and decode
        remote_gray = 4'b1101;
        step();
        check("sync_n1", remote_bin, 4'h0);
        step();
        check("sync_n2", remote_bin, 4'b1001);
        check("sync_dist", distance, 4'b0111);

        // Distance with wrap-around
        remote_gray = 4'b1011;
        inc = 1'b1;
        step();
        step();
        check("dist_bin2", bin_ptr, 4'b0010);
        check("dist_rbin", remote_bin, 4'b1101);
        check("dist_5", distance, 4'b0101);
        remote_gray = 4'b1010;
        for (int i = 0; i < 10; i++) step();
        check("dist_bin12", bin_ptr, 4'b1100);
        check("dist_rbin12", remote_bin, 4'b1100);
        check("dist_0", distance, 4'h0);

        // clr leaves remote side alone
        inc = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_keep_rbin", remote_bin, 4'b1100);
        check("clr_local_bin", bin_ptr, 4'h0);

        // Local one behind remote
        remote_gray = 4'b0001;
        step();
        step();
        check("behind_dist", distance, 4'hF);

        // Asynchronous reset mid-count
        inc = 1'b1;
        remote_gray = 4'b0011;
        step();
        step();
        step();
        check("mid_bin", bin_ptr, 4'h3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_bin", bin_ptr, 4'h0);
        check("async_gray", gray_ptr, 4'h0);
        check("async_rbin", remote_bin, 4'h0);
        step();
        rst_n = 1'b1;
        step();
        check("post_bin", bin_ptr, 4'h1);
        check("post_gray", gray_ptr, 4'h1);
        check("post_rbin", remote_bin, 4'h0);
        check("post_dist", distance, 4'h1);
        step();
        check("post_rbin2", remote_bin, 4'b0010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
